// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write-back queue:
// default widths, the queue entry layout and the address legality check.
package wb_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 16;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Only the lower NREGS addresses map onto implemented registers
    function automatic logic addr_legal(input logic [ADDR_W-1:0] a);
        return int'(a) < NREGS;
    endfunction

endpackage

// File: rtl/wb_fwd_cam.sv
// DEPTH-way address compare over the pending write-back entries.
// Walks the entries from oldest (rd_ptr) to youngest so the last match wins,
// which gives readers the value that will be in the register after draining.
module wb_fwd_cam
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH),
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic [DEPTH-1:0][ADDR_W-1:0] addrs,
    input  logic [DEPTH-1:0][DATA_W-1:0] datas,
    input  logic [PTR_W-1:0]             rd_ptr,
    input  logic [CNT_W-1:0]             count,
    input  logic [ADDR_W-1:0]            query,
    output logic                         hit,
    output logic [DATA_W-1:0]            data
);

    logic [PTR_W-1:0] idx;

    // Oldest-to-youngest scan restricted to occupied slots; later matches override
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTR_W'(k);
            if ((CNT_W'(k) < count) && (addrs[idx] == query)) begin
                hit  = 1'b1;
                data = datas[idx];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// Write-back queue feeding the register-file write port.
// Buffers execute results in a DEPTH-entry FIFO and retires one per cycle.
// Optional read-port forwarding is enabled with the WB_FWD_EN macro.
module regfile_wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_data,
    input  logic              wb_hold,
    output logic [ADDR_W-1:0] wb_addrc,
    output logic [DATA_W-1:0] wb_dinc,
    output logic              wb_wrback,
    input  logic [ADDR_W-1:0] q_addr_a,
    input  logic [ADDR_W-1:0] q_addr_b,
    output logic              fwd_hit_a,
    output logic [DATA_W-1:0] fwd_data_a,
    output logic              fwd_hit_b,
    output logic [DATA_W-1:0] fwd_data_b,
    output logic              idle,
    output logic              addr_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    wb_entry_t        mem_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             addr_err_reg;

    logic empty;
    logic accept;
    logic push;
    logic pop;

    assign empty    = (count_reg == '0);
    assign in_ready = (count_reg < CNT_W'(DEPTH));
    assign accept   = in_valid & in_ready;
    // Illegal destinations complete the handshake but never enter the FIFO
    assign push     = accept & addr_legal(in_addr);
    assign pop      = ~empty & ~wb_hold;

    assign wb_wrback = pop;
    assign wb_addrc  = empty ? '0 : mem_reg[rd_ptr_reg].addr;
    assign wb_dinc   = empty ? '0 : mem_reg[rd_ptr_reg].data;
    assign idle      = empty;
    assign addr_err  = addr_err_reg;

    // Pointer, occupancy and sticky error bookkeeping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= '0;
            addr_err_reg <= 1'b0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push && !pop)      count_reg <= count_reg + 1'b1;
            else if (!push && pop) count_reg <= count_reg - 1'b1;
            if (accept && !addr_legal(in_addr)) addr_err_reg <= 1'b1;
        end
    end

    // Entry storage; slots outside the occupied window are don't-care
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
        end else if (push) begin
            mem_reg[wr_ptr_reg] <= '{addr: in_addr, data: in_data};
        end
    end

`ifdef WB_FWD_EN
    logic [DEPTH-1:0][ADDR_W-1:0] cam_addrs;
    logic [DEPTH-1:0][DATA_W-1:0] cam_datas;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cam_flat
        assign cam_addrs[gi] = mem_reg[gi].addr;
        assign cam_datas[gi] = mem_reg[gi].data;
    end

    wb_fwd_cam #(.DEPTH(DEPTH)) u_cam_a (
        .addrs (cam_addrs),
        .datas (cam_datas),
        .rd_ptr(rd_ptr_reg),
        .count (count_reg),
        .query (q_addr_a),
        .hit   (fwd_hit_a),
        .data  (fwd_data_a)
    );

    wb_fwd_cam #(.DEPTH(DEPTH)) u_cam_b (
        .addrs (cam_addrs),
        .datas (cam_datas),
        .rd_ptr(rd_ptr_reg),
        .count (count_reg),
        .query (q_addr_b),
        .hit   (fwd_hit_b),
        .data  (fwd_data_b)
    );
`else
    logic unused_query;
    assign unused_query = ^{q_addr_a, q_addr_b};
    assign fwd_hit_a    = 1'b0;
    assign fwd_data_a   = '0;
    assign fwd_hit_b    = 1'b0;
    assign fwd_data_b   = '0;
`endif

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Bench for regfile_wb_queue: a queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        wb_hold;
    logic [4:0]  wb_addrc;
    logic [31:0] wb_dinc;
    logic        wb_wrback;
    logic [4:0]  q_addr_a;
    logic [4:0]  q_addr_b;
    logic        fwd_hit_a;
    logic [31:0] fwd_data_a;
    logic        fwd_hit_b;
    logic [31:0] fwd_data_b;
    logic        idle;
    logic        addr_err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .wb_hold(wb_hold),
        .wb_addrc(wb_addrc), .wb_dinc(wb_dinc), .wb_wrback(wb_wrback),
        .q_addr_a(q_addr_a), .q_addr_b(q_addr_b),
        .fwd_hit_a(fwd_hit_a), .fwd_data_a(fwd_data_a),
        .fwd_hit_b(fwd_hit_b), .fwd_data_b(fwd_data_b),
        .idle(idle), .addr_err(addr_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: the pending results as a plain ordered list
    typedef struct { logic [4:0] a; logic [31:0] d; } ent_t;
    ent_t mq[$];
    logic merr;
    int   m_sz;
    logic m_push, m_pop;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            merr = 1'b0;
        end else begin
            m_sz   = mq.size();
            m_push = in_valid && (m_sz < DEPTH);
            m_pop  = (m_sz > 0) && !wb_hold;
            if (m_pop) void'(mq.pop_front());
            if (m_push) begin
                if (in_addr < 5'd16) mq.push_back('{a: in_addr, d: in_data});
                else merr = 1'b1;
            end
        end
    end

    function automatic logic [32:0] model_fwd(input logic [4:0] q);
        logic [32:0] r = '0;
`ifdef WB_FWD_EN
        foreach (mq[i]) if (mq[i].a == q) r = {1'b1, mq[i].d};
`endif
        return r;
    endfunction

    // Per-cycle comparison of every output against the model
    logic [32:0] e_fa, e_fb;
    always @(negedge clk) begin
        e_fa = model_fwd(q_addr_a);
        e_fb = model_fwd(q_addr_b);
        chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
        chk("wb_wrback", 32'(wb_wrback), 32'((mq.size() > 0) && !wb_hold));
        chk("wb_addrc",  32'(wb_addrc),  (mq.size() > 0) ? 32'(mq[0].a) : 32'd0);
        chk("wb_dinc",   wb_dinc,        (mq.size() > 0) ? mq[0].d : 32'd0);
        chk("idle",      32'(idle),      32'(mq.size() == 0));
        chk("addr_err",  32'(addr_err),  32'(merr));
        chk("fwd_hit_a", 32'(fwd_hit_a), 32'(e_fa[32]));
        chk("fwd_data_a", fwd_data_a,    e_fa[31:0]);
        chk("fwd_hit_b", 32'(fwd_hit_b), 32'(e_fb[32]));
        chk("fwd_data_b", fwd_data_b,    e_fb[31:0]);
    end

    // Offer one result for a single edge; caller sits at posedge+2
    task automatic push(input logic [4:0] a, input logic [31:0] d);
        in_valid = 1'b1; in_addr = a; in_data = d;
        @(posedge clk); #2;
        in_valid = 1'b0;
        $display("push addr=%0d data=0x%08h", a, d);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // Mixed stream with hold toggling: {valid, addr, data, hold}
    typedef struct { logic v; logic [4:0] a; logic [31:0] d; logic h; } vec_t;
    vec_t vecs[10] = '{
        '{1'b1, 5'd0,  32'h0000_0100, 1'b0},
        '{1'b1, 5'd15, 32'h0000_0101, 1'b0},
        '{1'b1, 5'd7,  32'h0000_0102, 1'b1},
        '{1'b1, 5'd7,  32'h0000_0103, 1'b1},
        '{1'b0, 5'd0,  32'h0,         1'b0},
        '{1'b1, 5'd9,  32'h0000_0104, 1'b1},
        '{1'b1, 5'd2,  32'h0000_0105, 1'b0},
        '{1'b0, 5'd0,  32'h0,         1'b1},
        '{1'b1, 5'd11, 32'h0000_0106, 1'b0},
        '{1'b0, 5'd0,  32'h0,         1'b0}
    };

    initial begin
        rst_n = 1'b0; in_valid = 1'b1; in_addr = 5'd3; in_data = 32'h1234;
        wb_hold = 1'b0; q_addr_a = 5'd5; q_addr_b = 5'd7;

        // Reset held with a valid offer present
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_wrback",   32'(wb_wrback), 32'd0);
        chk("rst_idle",     32'(idle), 32'd1);
        chk("rst_addr_err", 32'(addr_err), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1; in_valid = 1'b0;
        idle_cycles(1);

        // Single push latency
        push(5'd3, 32'hA5A5_0001);
        @(negedge clk);
        chk("lat_wrback", 32'(wb_wrback), 32'd1);
        chk("lat_addrc",  32'(wb_addrc), 32'd3);
        chk("lat_dinc",   wb_dinc, 32'hA5A5_0001);
        @(negedge clk);
        chk("lat_idle",   32'(idle), 32'd1);
        @(posedge clk); #2;

        // Fill under hold, try a push while full, then drain in order
        wb_hold = 1'b1;
        for (int i = 1; i <= 4; i++) push(5'(i), 32'h10 + 32'(i));
        chk("full_ready", 32'(in_ready), 32'd0);
        push(5'd6, 32'hDEAD);
        wb_hold = 1'b0;
        in_valid = 1'b1; in_addr = 5'd8; in_data = 32'h88;
        #1;
        chk("drain1_addrc", 32'(wb_addrc), 32'd1);
        @(posedge clk); #2;
        in_valid = 1'b0;
        chk("drain2_ready", 32'(in_ready), 32'd1);
        chk("drain2_addrc", 32'(wb_addrc), 32'd2);
        idle_cycles(4);
        chk("drain_idle", 32'(idle), 32'd1);

        // Push and pop on the same edge with one entry pending
        push(5'd12, 32'hC0);
        push(5'd13, 32'hC1);
        chk("cnt1_addrc", 32'(wb_addrc), 32'd13);
        idle_cycles(2);

        // Same-address forwarding
        wb_hold = 1'b1;
        push(5'd5, 32'd1);
        push(5'd5, 32'd2);
        @(negedge clk);
`ifdef WB_FWD_EN
        chk("fwd_hit_lit",  32'(fwd_hit_a), 32'd1);
        chk("fwd_data_lit", fwd_data_a, 32'd2);
`else
        chk("fwd_hit_lit",  32'(fwd_hit_a), 32'd0);
        chk("fwd_data_lit", fwd_data_a, 32'd0);
`endif
        @(posedge clk); #2;
        wb_hold = 1'b0;
        idle_cycles(3);

        // Mixed stream with hold dropping mid-stream
        foreach (vecs[i]) begin
            in_valid = vecs[i].v; in_addr = vecs[i].a; in_data = vecs[i].d;
            wb_hold = vecs[i].h; q_addr_a = vecs[i].a; q_addr_b = 5'd7;
            @(posedge clk); #2;
            $display("vec %0d valid=%0d addr=%0d hold=%0d", i, vecs[i].v, vecs[i].a, vecs[i].h);
        end
        in_valid = 1'b0; wb_hold = 1'b0;
        idle_cycles(6);

        // Illegal destination: boundary 16 and 20
        push(5'd16, 32'hBAD0);
        @(negedge clk);
        chk("ill_wrback", 32'(wb_wrback), 32'd0);
        chk("ill_err",    32'(addr_err), 32'd1);
        @(posedge clk); #2;
        push(5'd20, 32'hBAD1);
        idle_cycles(3);
        chk("ill_sticky", 32'(addr_err), 32'd1);

        // Reset in the middle of a drain
        wb_hold = 1'b1;
        push(5'd1, 32'hE1);
        push(5'd2, 32'hE2);
        push(5'd3, 32'hE3);
        wb_hold = 1'b0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_wrback", 32'(wb_wrback), 32'd0);
        chk("mid_rst_idle",   32'(idle), 32'd1);
        chk("mid_rst_err",    32'(addr_err), 32'd0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        idle_cycles(2);
        push(5'd4, 32'hF4);
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
